// File: rtl/nibble_add_seq.sv
// nibble_add_seq: W-bit add/subtract performed one nibble per clock through an
// external 4-bit adder. A+B, or A-B computed as A + ~B + 1.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_ci,
  input  logic [3:0]             add_s,
  input  logic                   add_co,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy,
  output logic                   done
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic            carry;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            sub_reg;

  // Control FSM, operand latches, nibble result assembly and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sub_reg <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            sub_reg <= sub;
            k       <= '0;
            carry   <= sub;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          result[{k, 2'b00} +: 4] <= add_s;
          carry <= add_co;
          k     <= k + 1'b1;
          if (k == LAST) begin
            // add_s[3] is the new result MSB being written this edge
            cout  <= add_co;
            ovf   <= (a_reg[W-1] == (b_reg[W-1] ^ sub_reg)) &&
                     (add_s[3] != a_reg[W-1]);
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Adder operand steering: active nibble only while running, zero otherwise
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state == RUN) begin
      add_a  = a_reg[{k, 2'b00} +: 4];
      add_b  = b_reg[{k, 2'b00} +: 4] ^ {4{sub_reg}};
      add_ci = carry;
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: directed checks of nibble_add_seq with a behavioural
// 4-bit adder closing the external adder loop.
module tb_nibble_add_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_ci, add_co;
  logic [15:0] result;
  logic        cout, ovf, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] tr_a [4];
  logic [3:0] tr_b [4];
  logic       tr_c [4];

  always #5 clk = ~clk;

  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};

  nibble_add_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .op_a(op_a), .op_b(op_b),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain op; 1: start re-pulsed with new operands in RUN cycle 1;
  // 2: reset pulsed in RUN cycle 2 (expects operands 0x1234 + 0x1111)
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int mode,
                        input logic [15:0] exp_res, input logic exp_co, input logic exp_ov);
    int cyc = 0;
    int idx = 0;
    int bcnt = 0;
    int dseen = 0;
    logic got = 1'b0;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " clear@start"}, {15'b0, result, cout, ovf}, 32'h0);
    while (cyc < 20 && !got) begin
      if (busy) begin
        bcnt++;
        if (idx < 4) begin
          tr_a[idx] = add_a; tr_b[idx] = add_b; tr_c[idx] = add_ci;
          idx++;
        end
      end
      if (mode == 1 && idx == 2) begin
        start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; sub = ~s;
      end else begin
        start = 1'b0;
      end
      if (mode == 2 && idx == 3) begin
        check({name, " partial"}, {16'b0, result}, 32'h0045);
        rst = 1'b1;
        #1;
        check({name, " rst busy"}, {31'b0, busy}, 32'h0);
        check({name, " rst result"}, {16'b0, result}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
          @(posedge clk); #1;
          if (done) dseen++;
        end
        check({name, " no done after abort"}, dseen, 32'h0);
        return;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    check({name, " done seen"}, {31'b0, got}, 32'h1);
    check({name, " latency"}, cyc, 32'd4);
    check({name, " busy cycles"}, bcnt, 32'd4);
    check({name, " result"}, {16'b0, result}, {16'b0, exp_res});
    check({name, " cout"}, {31'b0, cout}, {31'b0, exp_co});
    check({name, " ovf"}, {31'b0, ovf}, {31'b0, exp_ov});
    @(posedge clk); #1;
    check({name, " done pulse width"}, {31'b0, done}, 32'h0);
    check({name, " result hold"}, {16'b0, result}, {16'b0, exp_res});
    check({name, " idle adder"}, {23'b0, add_a, add_b, add_ci}, 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset outs", {12'b0, result, cout, ovf, busy, done}, 32'h0);
    check("reset adder", {23'b0, add_a, add_b, add_ci}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add basic", 16'h1234, 16'h1111, 1'b0, 0, 16'h2345, 1'b0, 1'b0);
    run_op("add wrap",  16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
    run_op("add ovf",   16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
    run_op("sub borrow",16'h0005, 16'h0007, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub ovf",   16'h8000, 16'h0001, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1);

    run_op("sub trace", 16'h00F0, 16'h0010, 1'b1, 0, 16'h00E0, 1'b1, 1'b0);
    check("trace c0", {23'b0, tr_a[0], tr_b[0], tr_c[0]}, {23'b0, 4'h0, 4'hF, 1'b1});
    check("trace c1", {23'b0, tr_a[1], tr_b[1], tr_c[1]}, {23'b0, 4'hF, 4'hE, 1'b1});
    check("trace c2", {23'b0, tr_a[2], tr_b[2], tr_c[2]}, {23'b0, 4'h0, 4'hF, 1'b1});
    check("trace c3", {23'b0, tr_a[3], tr_b[3], tr_c[3]}, {23'b0, 4'h0, 4'hF, 1'b1});

    run_op("start in run", 16'h1234, 16'h1111, 1'b0, 1, 16'h2345, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("no queued op", {30'b0, busy, done}, 32'h0);

    run_op("rst in run", 16'h1234, 16'h1111, 1'b0, 2, 16'h0, 1'b0, 1'b0);
    run_op("after rst", 16'h4321, 16'h0F0F, 1'b0, 0, 16'h5230, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
